// File: rtl/result_checker_if.sv
// -----------------------------------------------------------------------------
// result_checker_if
//
// Groups the signals the result checker listens to: the snooped CPU data-write
// bus and the write port used to preload the expected-value RAM.
//
//   addr      [ADDR_W]  snooped write word address
//   data      [DATA_W]  snooped write data (bus byte order)
//   wen                 snooped write enable
//   exp_we              expected-RAM write strobe
//   exp_addr  [IDX_W]   expected-RAM write index
//   exp_data  [DATA_W]  expected-RAM write data (readable byte order)
//
// Modports: master drives all signals (CPU side / test harness), slave
// receives them (the checker).
// -----------------------------------------------------------------------------
interface result_checker_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 10
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              wen;
  logic              exp_we;
  logic [IDX_W-1:0]  exp_addr;
  logic [DATA_W-1:0] exp_data;

  modport master (output addr, data, wen, exp_we, exp_addr, exp_data);
  modport slave  (input  addr, data, wen, exp_we, exp_addr, exp_data);
endinterface

// File: rtl/result_checker.sv
// -----------------------------------------------------------------------------
// result_checker
//
// Self-check block for the L2-cache system test. Snoops CPU stores to the
// test-port word address. A store of BEGIN_SYM starts a run; the following
// CHECK_NUM stores are compared, in order, against an expected-value RAM.
// The run then parks in REPORT (sticky until reset) with the error count,
// the number of cycles spent checking and the index of the first mismatch.
//
// Ports:
//   clk            in   clock, all state on the rising edge
//   rst            in   asynchronous, active-low reset
//   bus            slave modport of result_checker_if (snooped bus + RAM load)
//   finish         out  high while in REPORT
//   error_num      out  saturating mismatch count (all-ones = not started)
//   duration       out  saturating count of edges spent in CHECK
//   first_err_idx  out  index of the first mismatch of the run
//   first_err_vld  out  first_err_idx holds a valid index
//   mismatch       out  one-cycle pulse per failing compare
//   timeout        out  run ended by the idle timeout
//
// Configuration macro:
//   CHK_TIMEOUT_EN  when defined, a run that sees TIMEOUT_CYC consecutive
//                   idle cycles in CHECK ends in REPORT with timeout=1.
//                   When undefined, timeout is tied low and a run ends only
//                   after CHECK_NUM compares.
// -----------------------------------------------------------------------------
module result_checker #(
  parameter int                ADDR_W      = 30,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] TEST_PORT   = ADDR_W'(30'h3FF),
  parameter logic [DATA_W-1:0] BEGIN_SYM   = DATA_W'(32'h00000168),
  parameter int                IDX_W       = 10,
  parameter int                CHECK_NUM   = 353,
  parameter int                ERR_W       = 8,
  parameter int                DUR_W       = 16,
  parameter int                SWAP_BYTES  = 1,
  parameter int                TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  result_checker_if.slave   bus,
  output logic              finish,
  output logic [ERR_W-1:0]  error_num,
  output logic [DUR_W-1:0]  duration,
  output logic [IDX_W-1:0]  first_err_idx,
  output logic              first_err_vld,
  output logic              mismatch,
  output logic              timeout
);

  localparam int NBYTES = DATA_W / 8;
  // Index width that exactly addresses CHECK_NUM RAM entries.
  localparam int MEM_AW = (CHECK_NUM > 1) ? $clog2(CHECK_NUM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHECK_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_REPORT
  } state_t;

  state_t            state;
  logic              wen_q;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] cdata;
  logic [DATA_W-1:0] exp_word;
  logic              evt;
  logic              word_bad;

  logic [DATA_W-1:0] mem [CHECK_NUM];

  // ---------------------------------------------------------------------------
  // Byte order: the bus is little-endian, the expected RAM holds readable
  // values, so byte k of the bus word becomes byte NBYTES-1-k.
  // ---------------------------------------------------------------------------
  if (SWAP_BYTES != 0) begin : g_swap
    for (genvar k = 0; k < NBYTES; k++) begin : g_byte
      assign cdata[(NBYTES-1-k)*8 +: 8] = bus.data[k*8 +: 8];
    end
  end else begin : g_raw
    assign cdata = bus.data;
  end

  // A store stalled by the D-cache keeps wen high for several cycles; only
  // the rising edge of wen counts, so each store is seen exactly once.
  assign evt      = bus.wen && !wen_q && (bus.addr == TEST_PORT);
  assign exp_word = mem[idx[MEM_AW-1:0]];
  assign word_bad = (cdata != exp_word);

  // ---------------------------------------------------------------------------
  // Expected-value RAM. Writable in any state; a write to the entry being
  // compared in the same cycle lands after the compare has used the old word.
  // ---------------------------------------------------------------------------
  // NOTE: the RAM has no reset branch on purpose -- its contents must survive
  // rst, and leaving it out of reset keeps it mappable onto block RAM.
  always_ff @(posedge clk) begin
    if (bus.exp_we && (int'(bus.exp_addr) < CHECK_NUM)) begin
      mem[bus.exp_addr[MEM_AW-1:0]] <= bus.exp_data;
    end
  end

`ifdef CHK_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  // Idle cycles since the last accepted store or since entering CHECK.
  logic [TO_W-1:0] idle_cnt;
`else
  // Keeps the timeout parameter referenced when the idle counter is not built.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign timeout            = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // ---------------------------------------------------------------------------
  // NOTE: every register here is assigned with <= so that all of them sample
  // the pre-edge values of idx, error_num, etc.; blocking assignments would
  // let later statements see half-updated state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      wen_q         <= 1'b0;
      idx           <= '0;
      finish        <= 1'b0;
      error_num     <= '1;
      duration      <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
      mismatch      <= 1'b0;
`ifdef CHK_TIMEOUT_EN
      timeout       <= 1'b0;
      idle_cnt      <= '0;
`endif
    end else begin
      wen_q    <= bus.wen;
      mismatch <= 1'b0;

      case (state)
        S_IDLE: begin
          if (evt && (cdata == BEGIN_SYM)) begin
            state         <= S_CHECK;
            error_num     <= '0;
            idx           <= '0;
            duration      <= '0;
            first_err_vld <= 1'b0;
`ifdef CHK_TIMEOUT_EN
            idle_cnt      <= '0;
`endif
          end
        end

        S_CHECK: begin
          // Counts every edge spent in CHECK, the exit edge included.
          if (duration != '1) begin
            duration <= duration + 1'b1;
          end

          if (evt) begin
            idx <= idx + 1'b1;
            if (word_bad) begin
              mismatch <= 1'b1;
              if (error_num != '1) begin
                error_num <= error_num + 1'b1;
              end
              if (!first_err_vld) begin
                first_err_idx <= idx;
                first_err_vld <= 1'b1;
              end
            end
            if (idx == LAST_IDX) begin
              state  <= S_REPORT;
              finish <= 1'b1;
            end
`ifdef CHK_TIMEOUT_EN
            idle_cnt <= '0;
`endif
          end
`ifdef CHK_TIMEOUT_EN
          else if (idle_cnt == TO_LAST) begin
            // Unchecked entries are not counted as errors.
            state   <= S_REPORT;
            finish  <= 1'b1;
            timeout <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
`endif
        end

        S_REPORT: begin
          // Sticky until reset; further stores are ignored.
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_checker.sv
// -----------------------------------------------------------------------------
// tb_result_checker
//
// Self-checking bench for result_checker. Stores are driven on the snooped bus
// and simultaneously fed to a store-level reference model (expected-RAM copy,
// run mode, error count, first failing index, begin/end edge numbers). After
// each run the DUT outputs are compared against the model. Build with
// +define+CHK_TIMEOUT_EN to add the idle-timeout run.
// -----------------------------------------------------------------------------
module tb_result_checker;

  localparam int ADDR_W      = 30;
  localparam int DATA_W      = 32;
  localparam int IDX_W       = 3;
  localparam int CHECK_NUM   = 6;
  localparam int ERR_W       = 2;
  localparam int DUR_W       = 4;
  localparam int TIMEOUT_CYC = 16;
  localparam logic [ADDR_W-1:0] TEST_PORT = 30'h3FF;
  localparam logic [DATA_W-1:0] BEGIN_SYM = 32'h00000168;
  localparam int ERR_MAX = (1 << ERR_W) - 1;
  localparam int DUR_MAX = (1 << DUR_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             finish;
  logic [ERR_W-1:0] error_num;
  logic [DUR_W-1:0] duration;
  logic [IDX_W-1:0] first_err_idx;
  logic             first_err_vld;
  logic             mismatch;
  logic             timeout;

  result_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

  result_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TEST_PORT(TEST_PORT), .BEGIN_SYM(BEGIN_SYM),
    .IDX_W(IDX_W), .CHECK_NUM(CHECK_NUM), .ERR_W(ERR_W), .DUR_W(DUR_W),
    .SWAP_BYTES(1), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .finish(finish), .error_num(error_num), .duration(duration),
    .first_err_idx(first_err_idx), .first_err_vld(first_err_vld),
    .mismatch(mismatch), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_fail    = 0;
  int edge_cnt  = 0;
  int pulse_cnt = 0;

  always @(posedge clk) edge_cnt++;
  always @(negedge clk) if (mismatch) pulse_cnt++;

  // ---------------- reference model (store level) ----------------
  typedef enum int {M_IDLE, M_CHECK, M_DONE} mode_t;
  mode_t       m_mode;
  logic [31:0] m_mem [CHECK_NUM];
  int          m_err, m_n, m_first, m_vld, m_begin, m_last, m_pulses;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] swap(input logic [31:0] x);
    return {<<8{x}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_mode    = M_IDLE;
    m_err     = ERR_MAX;
    m_n       = 0;
    m_first   = 0;
    m_vld     = 0;
    m_begin   = 0;
    m_last    = 0;
    m_pulses  = 0;
    pulse_cnt = 0;
  endtask

  // One accepted store on the test port, seen at edge number e.
  task automatic model_event(input logic [31:0] bus_word, input int e);
    logic [31:0] v;
    v = swap(bus_word);
    case (m_mode)
      M_IDLE: if (v == BEGIN_SYM) begin
        m_mode = M_CHECK; m_err = 0; m_n = 0; m_vld = 0; m_begin = e;
      end
      M_CHECK: begin
        if (v != m_mem[m_n]) begin
          m_pulses++;
          if (m_err < ERR_MAX) m_err++;
          if (m_vld == 0) begin m_first = m_n; m_vld = 1; end
        end
        m_n++;
        if (m_n == CHECK_NUM) begin m_mode = M_DONE; m_last = e; end
      end
      default: ;
    endcase
  endtask

  task automatic exp_write(input int i, input logic [31:0] val);
    @(negedge clk);
    bus.exp_we = 1'b1; bus.exp_addr = IDX_W'(i); bus.exp_data = val;
    tick();
    @(negedge clk);
    bus.exp_we = 1'b0;
    m_mem[i] = val;
  endtask

  // Store readable value v to address a: wen held for `hold` edges, then low
  // for `gap` edges. Optionally writes the expected RAM in the event cycle.
  task automatic store(input logic [ADDR_W-1:0] a, input logic [31:0] v,
                       input int hold = 1, input int gap = 1,
                       input bit do_we = 1'b0, input int we_idx = 0,
                       input logic [31:0] we_val = 32'h0);
    logic [31:0] d;
    d = swap(v);
    @(negedge clk);
    bus.addr = a; bus.data = d; bus.wen = 1'b1;
    if (do_we) begin
      bus.exp_we = 1'b1; bus.exp_addr = IDX_W'(we_idx); bus.exp_data = we_val;
    end
    tick();
    if (a == TEST_PORT) model_event(d, edge_cnt);
    if (do_we) m_mem[we_idx] = we_val;
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      bus.exp_we = 1'b0;
      tick();
    end
    @(negedge clk);
    bus.wen = 1'b0; bus.exp_we = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1 model_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic check_results(input string tag);
    int exp_dur;
    case (m_mode)
      M_IDLE:  exp_dur = 0;
      M_CHECK: exp_dur = edge_cnt - m_begin;
      default: exp_dur = m_last - m_begin;
    endcase
    if (exp_dur > DUR_MAX) exp_dur = DUR_MAX;
    check({tag, ".finish"},   32'(finish),        32'(m_mode == M_DONE));
    check({tag, ".error_num"},32'(error_num),     32'(m_err));
    check({tag, ".duration"}, 32'(duration),      32'(exp_dur));
    check({tag, ".first_vld"},32'(first_err_vld), 32'(m_vld));
    check({tag, ".first_idx"},32'(first_err_idx), 32'(m_first));
    check({tag, ".pulses"},   32'(pulse_cnt),     32'(m_pulses));
    check({tag, ".mismatch"}, 32'(mismatch),      32'h0);
    check({tag, ".timeout"},  32'(timeout),       32'h0);
  endtask

  initial begin
    bus.addr = '0; bus.data = '0; bus.wen = 1'b0;
    bus.exp_we = 1'b0; bus.exp_addr = '0; bus.exp_data = '0;
    model_reset();
    for (int i = 0; i < CHECK_NUM; i++) m_mem[i] = 32'hx;

    // Reset state
    repeat (2) tick();
    check_results("reset");
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Clean run: mem[i] = i
    for (int i = 0; i < CHECK_NUM; i++) exp_write(i, 32'(i));
    store(TEST_PORT, BEGIN_SYM);
    for (int i = 0; i < CHECK_NUM; i++) store(TEST_PORT, 32'(i));
    check_results("clean");
    check("clean.dur_abs", 32'(duration), 32'(2 * CHECK_NUM));

    // Third store wrong; RAM must have survived the reset
    do_reset();
    store(TEST_PORT, BEGIN_SYM);
    for (int i = 0; i < CHECK_NUM; i++) store(TEST_PORT, (i == 2) ? 32'd7 : 32'(i));
    check_results("one_bad");
    check("one_bad.idx_abs", 32'(first_err_idx), 32'd2);

    // Stalled stores (wen held 5 cycles)
    do_reset();
    store(TEST_PORT, BEGIN_SYM, 5, 1);
    for (int i = 0; i < CHECK_NUM; i++) store(TEST_PORT, 32'(i), 5, 1);
    check_results("stall");
    check("stall.err_abs", 32'(error_num), 32'd0);

    // Non-events in IDLE, then reset in mid-run
    do_reset();
    store(30'h3FE, BEGIN_SYM);
    store(TEST_PORT, 32'h55);
    check_results("idle_ignore");
    store(TEST_PORT, BEGIN_SYM);
    store(TEST_PORT, 32'd0);
    store(TEST_PORT, 32'd9);
    check_results("mid_run");
    @(negedge clk);
    rst = 1'b0;
    #1 model_reset();
    check_results("async_rst");
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Error and duration saturation
    do_reset();
    store(TEST_PORT, BEGIN_SYM);
    for (int i = 0; i < CHECK_NUM; i++) store(TEST_PORT, (i < 5) ? 32'hDEAD : 32'(i), 1, 4);
    check_results("saturate");
    check("saturate.err_abs", 32'(error_num), 32'(ERR_MAX));
    check("saturate.dur_abs", 32'(duration),  32'(DUR_MAX));

    // Begin marker as data, and a RAM write colliding with the compare
    do_reset();
    exp_write(2, BEGIN_SYM);
    store(TEST_PORT, BEGIN_SYM);
    store(TEST_PORT, 32'd0);
    store(TEST_PORT, 32'd1, 1, 1, 1'b1, 1, 32'hABCD);
    for (int i = 2; i < CHECK_NUM; i++) store(TEST_PORT, m_mem[i]);
    check_results("collide");
    do_reset();
    store(TEST_PORT, BEGIN_SYM);
    for (int i = 0; i < CHECK_NUM; i++) store(TEST_PORT, (i == 1) ? 32'd1 : m_mem[i]);
    check_results("collide_after");

`ifdef CHK_TIMEOUT_EN
    do_reset();
    store(TEST_PORT, BEGIN_SYM);
    repeat (TIMEOUT_CYC - 2) tick();
    check("tmo.early_finish", 32'(finish), 32'h0);
    tick();
    check("tmo.finish",  32'(finish),    32'h1);
    check("tmo.timeout", 32'(timeout),   32'h1);
    check("tmo.err",     32'(error_num), 32'h0);
    check("tmo.dur",     32'(duration),  32'(DUR_MAX));
`endif

    // Randomized runs
    for (int r = 0; r < 12; r++) begin
      int nst;
      logic [31:0] v;
      do_reset();
      for (int j = 0; j < 2; j++)
        if ($urandom_range(0, 1) == 1) exp_write($urandom_range(0, CHECK_NUM - 1), 32'($urandom_range(0, 7)));
      if ($urandom_range(0, 2) == 0) store(TEST_PORT, 32'($urandom_range(0, 15)));
      store(TEST_PORT, BEGIN_SYM, $urandom_range(1, 3), $urandom_range(1, 4));
      nst = $urandom_range(3, CHECK_NUM + 1);
      for (int k = 0; k < nst; k++) begin
        if ($urandom_range(0, 3) == 0) store(30'h3FE, $urandom, $urandom_range(1, 3), $urandom_range(1, 4));
        if (m_mode == M_CHECK && $urandom_range(0, 2) != 0) v = m_mem[m_n];
        else v = 32'($urandom_range(0, 15));
        store(TEST_PORT, v, $urandom_range(1, 3), $urandom_range(1, 4));
      end
      check_results($sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
